square_wave_gen: RTL and testbench

Parametrised, clocked square/pulse waveform generator. It replaces the fixed-address, 10%-step square-wave table with:
- an NCO-style phase accumulator,
- fine-resolution duty cycle,
- programmable amplitude,
- unipolar and bipolar output modes.

New settings are applied glitch-free at the period boundary. It sits in the waveform generator beside the sine/triangle sources and feeds the DAC/sample path at the sample-strobe rate.

---
 rtl/square_wave_gen.sv | 105 ++++++++++
 tb/tb_square_wave_gen.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/square_wave_gen.sv
// Square/pulse waveform generator: NCO phase accumulator, fine duty compare,
// programmable amplitude, unipolar/bipolar output, settings applied at period boundary.
module square_wave_gen #(
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned DUTY_W = 10,
  parameter int unsigned DATA_W = 24
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic [ACC_W-1:0]  i_ftw,
  input  logic [DUTY_W:0]   i_duty,
  input  logic [DATA_W-2:0] i_amp,
  input  logic              i_mode,
  input  logic              i_load,
  input  logic              i_sync,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_wrap,
  output logic              o_pend
);

  typedef struct packed {
    logic [ACC_W-1:0]  ftw;
    logic [DUTY_W:0]   duty;
    logic [DATA_W-2:0] amp;
    logic              mode;
  } cfg_t;

  cfg_t              r_act;
  cfg_t              r_pnd;
  logic [ACC_W-1:0]  r_acc;
  logic              r_pend;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_wrap;

  cfg_t              w_in;
  cfg_t              w_cfg;
  logic [ACC_W-1:0]  w_ftw;
  logic [ACC_W:0]    w_sum;
  logic [ACC_W-1:0]  w_acc_next;
  logic [DUTY_W-1:0] w_phase;
  logic [DATA_W-1:0] w_mag;
  logic [DATA_W-1:0] w_sample;
  logic              w_idle_apply;
  logic              w_carry;
  logic              w_apply;
  logic              w_high;

  // Phase step, boundary detection and sample formation for this strobe
  always_comb begin
    w_in.ftw     = i_ftw;
    w_in.duty    = i_duty;
    w_in.amp     = i_amp;
    w_in.mode    = i_mode;
    // An idle generator takes pending settings at once, including for this step
    w_idle_apply = r_pend && (r_act.ftw == '0);
    w_ftw        = w_idle_apply ? r_pnd.ftw : r_act.ftw;
    w_sum        = {1'b0, r_acc} + {1'b0, w_ftw};
    w_carry      = w_sum[ACC_W] | i_sync;
    w_acc_next   = i_sync ? '0 : w_sum[ACC_W-1:0];
    w_apply      = w_idle_apply | (i_en & r_pend & w_carry);
    w_cfg        = w_apply ? r_pnd : r_act;
    w_phase      = w_acc_next[ACC_W-1 -: DUTY_W];
    w_high       = ({1'b0, w_phase} < w_cfg.duty);
    w_mag        = {1'b0, w_cfg.amp};
    w_sample     = '0;
    if (w_high)
      w_sample = w_mag;
    else if (w_cfg.mode)
      w_sample = DATA_W'(-w_mag);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_act   <= '0;
      r_pnd   <= '0;
      r_acc   <= '0;
      r_pend  <= 1'b0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      if (i_load)
        r_pnd <= w_in;
      // Active takes the old pending set even if a new load lands this cycle
      if (w_apply)
        r_act <= r_pnd;
      r_pend  <= i_load | (r_pend & ~w_apply);
      r_valid <= i_en;
      r_wrap  <= i_en & w_carry;
      if (i_en) begin
        r_acc  <= w_acc_next;
        r_data <= w_sample;
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_wrap  = r_wrap;
  assign o_pend  = r_pend;

endmodule

// File: tb/tb_square_wave_gen.sv
// Scoreboard bench for square_wave_gen: behavioural model pushes expected samples,
// monitor pops and compares on o_valid; window counters check period shapes.
module tb_square_wave_gen;

  localparam int unsigned ACC_W  = 32;
  localparam int unsigned DUTY_W = 10;
  localparam int unsigned DATA_W = 24;
  localparam logic [31:0] F  = 32'h0040_0000;
  localparam logic [22:0] A1 = 23'h1F_FFFF;
  localparam logic [22:0] AM = 23'h7F_FFFF;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_en, i_load, i_sync, i_mode;
  logic [ACC_W-1:0]  i_ftw;
  logic [DUTY_W:0]   i_duty;
  logic [DATA_W-2:0] i_amp;
  logic [DATA_W-1:0] o_data;
  logic              o_valid, o_wrap, o_pend;

  int n_chk = 0;
  int n_err = 0;

  // model state
  logic [31:0] m_acc, m_ftw, p_ftw;
  logic [10:0] m_duty, p_duty;
  logic [22:0] m_amp, p_amp;
  logic        m_mode, p_mode, m_pend;
  logic [24:0] sb[$];
  logic [23:0] hold_exp = 24'h0;
  logic [23:0] ref_a = 24'h0, ref_b = 24'h0;
  int cnt_a = 0, cnt_b = 0, cnt_w = 0;

  square_wave_gen #(.ACC_W(ACC_W), .DUTY_W(DUTY_W), .DATA_W(DATA_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(i_en), .i_ftw(i_ftw), .i_duty(i_duty),
    .i_amp(i_amp), .i_mode(i_mode), .i_load(i_load), .i_sync(i_sync),
    .o_data(o_data), .o_valid(o_valid), .o_wrap(o_wrap), .o_pend(o_pend)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_ftw = 0; m_duty = 0; m_amp = 0; m_mode = 0;
    p_ftw = 0; p_duty = 0; p_amp = 0; p_mode = 0; m_pend = 0;
    sb.delete();
    hold_exp = 24'h0;
  endtask

  // One clock: drive at negedge, step the model, release strobes after the edge
  task automatic cyc(input logic en, input logic ld, input logic sy, input logic [31:0] f,
                     input logic [10:0] d, input logic [22:0] a, input logic m);
    logic [32:0] s;
    logic        c, hi;
    logic [9:0]  ph;
    logic [23:0] mag, dat;
    @(negedge clk);
    check("pend", 32'(o_pend), 32'(m_pend));
    i_en = en; i_load = ld; i_sync = sy; i_ftw = f; i_duty = d; i_amp = a; i_mode = m;
    if (m_pend && m_ftw == 0) begin
      m_ftw = p_ftw; m_duty = p_duty; m_amp = p_amp; m_mode = p_mode; m_pend = 0;
    end
    if (en) begin
      s = {1'b0, m_acc} + {1'b0, m_ftw};
      c = s[32] | sy;
      if (sy) s = 33'h0;
      if (c && m_pend) begin
        m_ftw = p_ftw; m_duty = p_duty; m_amp = p_amp; m_mode = p_mode; m_pend = 0;
      end
      ph  = s[31:22];
      hi  = ({1'b0, ph} < m_duty);
      mag = {1'b0, m_amp};
      dat = hi ? mag : (m_mode ? 24'(-mag) : 24'h0);
      m_acc = s[31:0];
      sb.push_back({dat, c});
    end
    if (ld) begin
      p_ftw = f; p_duty = d; p_amp = a; p_mode = m; m_pend = 1;
    end
    @(posedge clk);
    #1;
    i_en = 0; i_load = 0; i_sync = 0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 1'b0, 32'h0, 11'h0, 23'h0, 1'b0);
  endtask

  task automatic clr();
    #3;
    cnt_a = 0; cnt_b = 0; cnt_w = 0;
  endtask

  task automatic win(input string tag, input int ea, input int eb, input int ew);
    #3;
    check({tag, "_cnt_a"}, 32'(cnt_a), 32'(ea));
    check({tag, "_cnt_b"}, 32'(cnt_b), 32'(eb));
    check({tag, "_wraps"}, 32'(cnt_w), 32'(ew));
    cnt_a = 0; cnt_b = 0; cnt_w = 0;
  endtask

  // Strobe until pending settings are applied (bounded)
  task automatic align(input string tag);
    int n = 0;
    while (o_pend === 1'b1 && n < 3000) begin
      run(1);
      n++;
    end
    check(tag, 32'(o_pend), 32'h0);
    clr();
  endtask

  // Scoreboard monitor: sample after each active edge
  always begin : mon
    logic        e_en;
    logic [24:0] e;
    @(posedge clk);
    e_en = i_en;
    #2;
    if (rst_n) begin
      check("valid", 32'(o_valid), 32'(e_en));
      if (o_valid) begin
        if (sb.size() == 0) check("sb_underflow", 32'(sb.size()), 32'h1);
        else begin
          e = sb.pop_front();
          check("data", 32'(o_data), 32'(e[24:1]));
          check("wrap", 32'(o_wrap), 32'(e[0]));
          hold_exp = e[24:1];
          if (o_data == ref_a) cnt_a++;
          if (o_data == ref_b) cnt_b++;
          if (o_wrap) cnt_w++;
        end
      end else begin
        check("hold", 32'(o_data), 32'(hold_exp));
        check("wrap_no_strobe", 32'(o_wrap), 32'h0);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1);
  end

  initial begin : stim
    rst_n = 0; i_en = 0; i_load = 0; i_sync = 0; i_mode = 0;
    i_ftw = '0; i_duty = '0; i_amp = '0;
    model_reset();
    #1;
    check("rst_data", 32'(o_data), 32'h0);
    check("rst_valid", 32'(o_valid), 32'h0);
    check("rst_wrap", 32'(o_wrap), 32'h0);
    check("rst_pend", 32'(o_pend), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    // 1: idle-apply and first periods
    ref_a = 24'h1F_FFFF; ref_b = 24'h0;
    cyc(1'b0, 1'b1, 1'b0, F, 11'd512, A1, 1'b0);
    check("t1_pend_set", 32'(o_pend), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 11'h0, 23'h0, 1'b0);
    check("t1_idle_apply", 32'(o_pend), 32'h0);
    clr();
    run(1023); win("t1_first", 511, 512, 0);
    run(1024); win("t1_steady", 512, 512, 1);

    // 2: duty extremes
    cyc(1'b1, 1'b1, 1'b0, F, 11'd0, A1, 1'b0);
    align("t2_apply0");
    run(2048); win("t2_duty0", 0, 2048, 2);
    cyc(1'b1, 1'b1, 1'b0, F, 11'd1024, A1, 1'b0);
    align("t2_apply1024");
    run(2048); win("t2_duty1024", 2048, 0, 2);

    // 3: bipolar full scale
    ref_a = 24'h7F_FFFF; ref_b = 24'h80_0001;
    cyc(1'b1, 1'b1, 1'b0, F, 11'd256, AM, 1'b1);
    align("t3_apply");
    run(1024); win("t3_bipolar", 256, 768, 1);

    // 4: mid-period update waits for the boundary
    ref_a = 24'h1F_FFFF; ref_b = 24'h0;
    cyc(1'b1, 1'b1, 1'b0, F, 11'd512, A1, 1'b0);
    align("t4_apply512");
    run(300);
    cyc(1'b1, 1'b1, 1'b0, F, 11'd100, A1, 1'b0);
    check("t4_pend_mid", 32'(o_pend), 32'h1);
    run(722); win("t4_old_period", 511, 512, 0);
    check("t4_pend_held", 32'(o_pend), 32'h1);
    run(1);
    check("t4_pend_drop", 32'(o_pend), 32'h0);
    clr();
    run(1023); win("t4_new_period", 99, 924, 0);

    // 5: sync colliding with a load
    run(100);
    cyc(1'b1, 1'b1, 1'b0, F, 11'd300, A1, 1'b0);
    clr();
    cyc(1'b1, 1'b1, 1'b1, F, 11'd700, A1, 1'b0);
    check("t5_pend_kept", 32'(o_pend), 32'h1);
    win("t5_sync", 1, 0, 1);
    run(1023); win("t5_old_pending", 299, 724, 0);
    check("t5_pend_still", 32'(o_pend), 32'h1);
    run(1);
    check("t5_pend_drop", 32'(o_pend), 32'h0);
    clr();
    run(1023); win("t5_new_pending", 699, 324, 0);

    // 6: gated strobes, then async reset mid-period
    for (int i = 0; i < 30; i++) cyc(1'((i % 3) == 0), 1'b0, 1'b0, 32'h0, 11'h0, 23'h0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, F, 11'd50, A1, 1'b0);
    @(negedge clk);
    check("t6_pre_valid", 32'(o_valid), 32'h1);
    check("t6_pre_data", 32'(o_data), 32'h1F_FFFF);
    check("t6_pre_pend", 32'(o_pend), 32'h1);
    #3 rst_n = 0;
    #1;
    check("t6_rst_data", 32'(o_data), 32'h0);
    check("t6_rst_valid", 32'(o_valid), 32'h0);
    check("t6_rst_wrap", 32'(o_wrap), 32'h0);
    check("t6_rst_pend", 32'(o_pend), 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    run(4);

    // zero-ftw constant output, wrap only through sync
    ref_a = 24'h00_0123; ref_b = 24'hFF_FEDD;
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 11'd5, 23'h123, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 11'h0, 23'h0, 1'b0);
    check("t6_idle_apply", 32'(o_pend), 32'h0);
    clr();
    run(20); win("t6_ftw0_high", 20, 0, 0);
    cyc(1'b1, 1'b0, 1'b1, 32'h0, 11'h0, 23'h0, 1'b0);
    win("t6_ftw0_sync", 1, 0, 1);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 11'd0, 23'h123, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 11'h0, 23'h0, 1'b0);
    clr();
    run(10); win("t6_ftw0_low", 0, 10, 0);

    repeat (3) @(negedge clk);
    check("sb_drain", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
